uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver: configurable data width, runtime-selectable parity and 1/2 stop bits, 3-sample majority voting, false-start rejection and separate parity/framing error flags. Sits between the RX_IN pad and the system-side consumer (register file / async FIFO write side). It replaces the fixed 8-bit receiver in new integrations. Back-to-back frames are supported with no idle gap.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
PRESCALE_W, 6, width of prescale input (oversampling ratio)
SYNC_STAGES, 2, RX_IN synchroniser depth; legal 2..3

Ports:
clck  input  1  system clock
rst  input  1  asynchronous active-low reset
rx_in  input  1  serial line, idle high, asynchronous to clck
prescale  input  PRESCALE_W  clck cycles per bit; legal even values 4..2^PRESCALE_W-2
par_en  input  1  1 = parity bit present
par_typ  input  1  0 = even, 1 = odd
stop2  input  1  1 = two stop bits, 0 = one
p_data  output  DATA_W  received word, LSB = first data bit
data_valid  output  1  one-cycle pulse, clean frame on p_data
par_err  output  1  one-cycle pulse, parity mismatch
frm_err  output  1  one-cycle pulse, a stop bit sampled 0

Behaviour:
- Clock and reset: one clock, clck. Reset rst is asynchronous, active-low. While rst=0: p_data=0, data_valid=0, par_err=0, frm_err=0, FSM=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through SYNC_STAGES flops; all logic below uses the synchronised value rxs.
- Config latch: on start-edge detection, copy prescale, par_en, par_typ and stop2 into shadow registers. Changes mid-frame are ignored until the next frame.
- Edge counter: ec runs 0..P-1 (P = latched prescale). On wrap it returns to 0 and increments the bit counter bc.
- Bit sampling: samples taken at ec = P/2-2, P/2-1 and P/2. The bit value is the majority of the 3 samples, decided at ec = P/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: a 1->0 transition on rxs clears ec/bc and latches config -> START.
- START: majority=1 -> false start, return to IDLE with no output pulse. Majority=0 -> continue to bit end, then DATA.
- DATA: DATA_W bits, LSB first, shifted into a shift register.
- After the last data bit: if par_en -> PARITY, else -> STOP.
- PARITY: error if XOR(data bits, parity bit) != par_typ.
- STOP: 1 or 2 stop bits. Each stop bit is evaluated at its midpoint decision; any 0 sets the frame-error condition.
- The FSM enters DONE at the decision of the last stop bit. It does not wait for the bit end, so a start edge in the second half of the stop bit is caught.
- DONE: lasts exactly one cycle, then IDLE. Outputs are registered from DONE:
  - no error: data_valid=1 and p_data <= shift register
  - parity error: par_err=1
  - any stop bit 0: frm_err=1
  - both errors: par_err and frm_err pulse together
  - on any error: data_valid=0 and p_data unchanged
- Output timing: pulses occur 1 cycle after the last-stop-bit decision, i.e. SYNC_STAGES+1 cycles after the corresponding line sample. p_data holds its value until the next clean frame.
- Glitch rejection: a low pulse shorter than 2 samples around the start midpoint is rejected as a false start.
- Line held low (break): produces frm_err after the frame, then the FSM waits in IDLE for the next falling edge. A continuous low never retriggers.
- Reset mid-frame: all state clears immediately. The partial frame produces no output.
- Out-of-range prescale (<4 or odd): behaviour undefined; the bench does not drive it.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE..DONE)
  - constant MAJ_OFFSETS (-2,-1,0 relative to P/2)
  - function maj3
  - legal-range constants for DATA_W and prescale
- Sub-module uart_os_sampler: edge counter, bit counter and 3-sample majority voter. Outputs bit_val, bit_strobe (decision cycle) and bit_end (wrap). The FSM, shift register, parity accumulator and output registers stay in the top level.

Test Plan:
- All scenarios use DATA_W=8 and prescale=8 unless stated.
1. par_en=1, par_typ=0; send 0xA5 with parity 0 and 1 stop bit -> one data_valid pulse, p_data=0xA5, no error pulses.
2. Same frame but parity bit=1 -> par_err pulse, data_valid=0, p_data keeps its previous value.
3. par_en=0, stop2=1; send 0x3C with second stop bit=0 -> frm_err pulse only. Then send 0x3C cleanly -> data_valid, p_data=0x3C.
4. 3-clck low glitch on an idle line -> no pulses, FSM back in IDLE. Then a single-cycle low inside data bit 3 of frame 0x00 -> p_data=0x00 (majority masks it).
5. Back-to-back frames 0x55 and 0xAA, next start edge directly after the stop bit, prescale=16 -> two data_valid pulses 10 bit-times apart, values 0x55 then 0xAA.
6. DATA_W=7, par_typ=1: rst=0 asserted mid-data, rx_in driven idle-high until rst=1 -> no pulses and all outputs 0 after reset. Then a full frame 0x41 -> data_valid, p_data=0x41.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types, constants and helpers for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Majority sample positions relative to the bit midpoint P/2
    localparam int MAJ_OFFSETS [3] = '{-2, -1, 0};

    localparam int unsigned DATA_W_MIN   = 5;
    localparam int unsigned DATA_W_MAX   = 9;
    localparam int unsigned PRESCALE_MIN = 4;

    // Bit counter width: start + up to 9 data + parity + 2 stop fits in 4 bits
    localparam int unsigned BC_W = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_sampler.sv
// Oversampling edge/bit counter with a 3-sample majority voter.
module uart_os_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_run,
    input  logic                  i_rxs,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_bit_val_c,
    output logic                  o_bit_strobe_c,
    output logic                  o_bit_end_c,
    output logic [BC_W-1:0]       o_bc
);

    logic [PRESCALE_W-1:0] r_ec;
    logic [BC_W-1:0]       r_bc;
    logic                  r_s0;
    logic                  r_s1;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_pos0;
    logic [PRESCALE_W-1:0] w_pos1;
    logic [PRESCALE_W-1:0] w_pos2;
    logic [PRESCALE_W-1:0] w_last;

    assign w_half = i_prescale >> 1;
    assign w_pos0 = w_half + PRESCALE_W'(MAJ_OFFSETS[0]);
    assign w_pos1 = w_half + PRESCALE_W'(MAJ_OFFSETS[1]);
    assign w_pos2 = w_half + PRESCALE_W'(MAJ_OFFSETS[2]);
    assign w_last = i_prescale - PRESCALE_W'(1);

    // Edge counter wraps at P-1 and advances the bit counter
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_ec <= '0;
            r_bc <= '0;
        end else if (i_clr) begin
            r_ec <= '0;
            r_bc <= '0;
        end else if (i_run) begin
            if (r_ec == w_last) begin
                r_ec <= '0;
                r_bc <= r_bc + BC_W'(1);
            end else begin
                r_ec <= r_ec + PRESCALE_W'(1);
            end
        end
    end

    // Capture the two early samples; the third is the live line at the decision
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (i_run) begin
            if (r_ec == w_pos0) r_s0 <= i_rxs;
            if (r_ec == w_pos1) r_s1 <= i_rxs;
        end
    end

    assign o_bit_val_c    = maj3(r_s0, r_s1, i_rxs);
    assign o_bit_strobe_c = i_run && (r_ec == w_pos2);
    assign o_bit_end_c    = i_run && (r_ec == w_last);
    assign o_bc           = r_bc;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority sampling, optional parity, 1/2 stop bits.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_W-1:0]     p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  frm_err
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                  r_rxs_d;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic [DATA_W-1:0]     r_shift;
    logic                  r_par_acc;
    logic                  r_par_bad;
    logic                  r_frm_bad;
    logic                  r_stop_seen;

    logic                  w_rxs;
    logic                  w_edge_ok;
    logic                  w_run;
    logic                  w_bit_val;
    logic                  w_strobe;
    logic                  w_bit_end;
    logic [BC_W-1:0]       w_bc;
    logic                  w_last_stop;
    logic                  w_frm_final;
    logic                  w_dv_nxt;
    logic                  w_pe_nxt;
    logic                  w_fe_nxt;

    // Synchronise the asynchronous line; idles high out of reset
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_rxs_d <= w_rxs;
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // A start edge is accepted in IDLE and in DONE so back-to-back frames at small P are not missed
    assign w_edge_ok = r_rxs_d && !w_rxs && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_run     = (r_state == ST_START) || (r_state == ST_DATA) ||
                       (r_state == ST_PARITY) || (r_state == ST_STOP);

    uart_os_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clck           (clck),
        .rst            (rst),
        .i_clr          (w_edge_ok),
        .i_run          (w_run),
        .i_rxs          (w_rxs),
        .i_prescale     (r_pre),
        .o_bit_val_c    (w_bit_val),
        .o_bit_strobe_c (w_strobe),
        .o_bit_end_c    (w_bit_end),
        .o_bc           (w_bc)
    );

    // State register
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_edge_ok) w_state_nxt = ST_START;
            ST_START: begin
                if (w_strobe && w_bit_val) w_state_nxt = ST_IDLE;
                else if (w_bit_end)        w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (w_bc == BC_W'(DATA_W)))
                    w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_last_stop) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = w_edge_ok ? ST_START : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode at the last stop-bit decision
    always_comb begin
        w_last_stop = 1'b0;
        w_frm_final = 1'b0;
        w_dv_nxt    = 1'b0;
        w_pe_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        if ((r_state == ST_STOP) && w_strobe && (!r_stop2 || r_stop_seen)) begin
            w_last_stop = 1'b1;
            w_frm_final = r_frm_bad || !w_bit_val;
            w_pe_nxt    = r_par_bad;
            w_fe_nxt    = w_frm_final;
            w_dv_nxt    = !r_par_bad && !w_frm_final;
        end
    end

    // Frame datapath: config shadow, shift register, parity and stop tracking
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_pre       <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_stop2     <= 1'b0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_bad   <= 1'b0;
            r_frm_bad   <= 1'b0;
            r_stop_seen <= 1'b0;
        end else if (w_edge_ok) begin
            r_pre       <= prescale;
            r_par_en    <= par_en;
            r_par_typ   <= par_typ;
            r_stop2     <= stop2;
            r_par_acc   <= 1'b0;
            r_par_bad   <= 1'b0;
            r_frm_bad   <= 1'b0;
            r_stop_seen <= 1'b0;
        end else if (w_strobe) begin
            case (r_state)
                ST_DATA: begin
                    r_shift   <= {w_bit_val, r_shift[DATA_W-1:1]};
                    r_par_acc <= r_par_acc ^ w_bit_val;
                end
                ST_PARITY: r_par_bad <= ((r_par_acc ^ w_bit_val) != r_par_typ);
                ST_STOP: begin
                    r_stop_seen <= 1'b1;
                    if (!w_bit_val) r_frm_bad <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered output pulses; p_data only updates on a clean frame
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            data_valid <= w_dv_nxt;
            par_err    <= w_pe_nxt;
            frm_err    <= w_fe_nxt;
            if (w_dv_nxt) p_data <= r_shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit and 7-bit instances.
module tb_uart_rx_param;
    import uart_rx_pkg::*;

    logic       clck = 1'b0;
    logic       rst, rst7, rx, rx7;
    logic [5:0] prescale;
    logic       par_en, par_typ, stop2;
    logic [7:0] p_data;
    logic       dv, pe, fe;
    logic [6:0] p_data7;
    logic       dv7, pe7, fe7;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int dv7_cnt = 0, pe7_cnt = 0, fe7_cnt = 0;
    logic [7:0] dv_q [$];
    time        t_q  [$];
    int         base;

    always #5 clck = ~clck;

    uart_rx_param #(.DATA_W(8), .PRESCALE_W(6), .SYNC_STAGES(2)) u_dut (
        .clck(clck), .rst(rst), .rx_in(rx), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .p_data(p_data), .data_valid(dv), .par_err(pe), .frm_err(fe)
    );

    uart_rx_param #(.DATA_W(7), .PRESCALE_W(6), .SYNC_STAGES(2)) u_dut7 (
        .clck(clck), .rst(rst7), .rx_in(rx7), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .p_data(p_data7), .data_valid(dv7), .par_err(pe7), .frm_err(fe7)
    );

    // Pulse monitor, sampled on the falling edge
    always @(negedge clck) begin
        if (dv) begin
            dv_cnt++;
            dv_q.push_back(p_data);
            t_q.push_back($time);
        end
        if (pe)  pe_cnt++;
        if (fe)  fe_cnt++;
        if (dv7) dv7_cnt++;
        if (pe7) pe7_cnt++;
        if (fe7) fe7_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx7 = v;
        else     rx  = v;
    endtask

    task automatic idle(input int n);
        rx  = 1'b1;
        rx7 = 1'b1;
        repeat (n) @(negedge clck);
    endtask

    // Serialise one frame; bit position gpos gets an inverted cycle at gcyc
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit,
                              input logic s1, input logic s2, input int nstop,
                              input int p, input int gpos, input int gcyc);
        logic [15:0] fr;
        int n;
        fr = '0;
        n  = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin fr[n] = data[i]; n++; end
        if (has_par) begin fr[n] = pbit; n++; end
        fr[n] = s1; n++;
        if (nstop == 2) begin fr[n] = s2; n++; end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                drive(sel, (b == gpos && c == gcyc) ? ~fr[b] : fr[b]);
                @(negedge clck);
            end
        end
    endtask

    initial begin
        rst = 1'b0; rst7 = 1'b0; rx = 1'b1; rx7 = 1'b1;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        repeat (3) @(negedge clck);
        chk("rst_p_data", 32'(p_data), 32'h0);
        chk("rst_dv", 32'(dv), 32'h0);
        chk("rst_pe", 32'(pe), 32'h0);
        chk("rst_fe", 32'(fe), 32'h0);
        rst = 1'b1; rst7 = 1'b1;
        idle(10);

        // 1: clean 0xA5, even parity bit 0
        send_frame(1'b0, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8, -1, 0);
        idle(20);
        chk("t1_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t1_pe_cnt", 32'(pe_cnt), 32'd0);
        chk("t1_fe_cnt", 32'(fe_cnt), 32'd0);
        chk("t1_p_data", 32'(p_data), 32'hA5);

        // 2: same frame with wrong parity bit
        send_frame(1'b0, 9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8, -1, 0);
        idle(20);
        chk("t2_pe_cnt", 32'(pe_cnt), 32'd1);
        chk("t2_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t2_fe_cnt", 32'(fe_cnt), 32'd0);
        chk("t2_p_data", 32'(p_data), 32'hA5);

        // 3: no parity, two stop bits, second stop low, then clean
        par_en = 1'b0; stop2 = 1'b1;
        send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8, -1, 0);
        idle(20);
        chk("t3_fe_cnt", 32'(fe_cnt), 32'd1);
        chk("t3_pe_cnt", 32'(pe_cnt), 32'd1);
        chk("t3_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t3_p_data_hold", 32'(p_data), 32'hA5);
        send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8, -1, 0);
        idle(20);
        chk("t3_clean_dv_cnt", 32'(dv_cnt), 32'd2);
        chk("t3_clean_p_data", 32'(p_data), 32'h3C);
        chk("t3_clean_fe_cnt", 32'(fe_cnt), 32'd1);

        // 4: 3-cycle low glitch on idle line, then 1-cycle disturbance in data bit 3
        stop2 = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clck);
        idle(30);
        chk("t4_glitch_dv", 32'(dv_cnt), 32'd2);
        chk("t4_glitch_pe", 32'(pe_cnt), 32'd1);
        chk("t4_glitch_fe", 32'(fe_cnt), 32'd1);
        chk("t4_state_idle", 32'(u_dut.r_state), 32'(ST_IDLE));
        send_frame(1'b0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8, 4, 4);
        idle(20);
        chk("t4_dv_cnt", 32'(dv_cnt), 32'd3);
        chk("t4_p_data", 32'(p_data), 32'h00);
        chk("t4_fe_cnt", 32'(fe_cnt), 32'd1);

        // 5: back-to-back 0x55 / 0xAA at prescale 16
        prescale = 6'd16;
        idle(5);
        base = dv_q.size();
        send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 16, -1, 0);
        send_frame(1'b0, 9'h0AA, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 16, -1, 0);
        idle(40);
        chk("t5_dv_cnt", 32'(dv_cnt), 32'd5);
        chk("t5_first", 32'(dv_q[base]), 32'h55);
        chk("t5_second", 32'(dv_q[base+1]), 32'hAA);
        chk("t5_spacing", 32'(t_q[base+1] - t_q[base]), 32'd1600);
        chk("t5_errs", 32'(pe_cnt + fe_cnt), 32'd2);

        // 6: 7-bit instance, odd parity, reset mid-data then a clean 0x41
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
        rx7 = 1'b0; repeat (8) @(negedge clck);
        rx7 = 1'b1; repeat (8) @(negedge clck);
        rx7 = 1'b0; repeat (8) @(negedge clck);
        rx7 = 1'b0; repeat (4) @(negedge clck);
        rst7 = 1'b0; rx7 = 1'b1;
        repeat (5) @(negedge clck);
        chk("t6_rst_p_data", 32'(p_data7), 32'h0);
        chk("t6_rst_state", 32'(u_dut7.r_state), 32'(ST_IDLE));
        rst7 = 1'b1;
        idle(100);
        chk("t6_no_dv", 32'(dv7_cnt), 32'd0);
        chk("t6_no_err", 32'(pe7_cnt + fe7_cnt), 32'd0);
        chk("t6_p_data_zero", 32'(p_data7), 32'h0);
        send_frame(1'b1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8, -1, 0);
        idle(20);
        chk("t6_dv_cnt", 32'(dv7_cnt), 32'd1);
        chk("t6_p_data", 32'(p_data7), 32'h41);
        chk("t6_err_cnt", 32'(pe7_cnt + fe7_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
